// File: rtl/time_set_ctrl.sv
// Time-set controller: debounced mode/up/down buttons drive an
// hrs/min/sec edit FSM that commits a new time with a one-cycle strobe.
module time_set_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_MS  = 10000,
  parameter int HR_MIN      = 0,
  parameter int HR_MAX      = 23
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_1khz_i,
  input  logic       btn_mode_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic [5:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       set_time_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_MS);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_MS);
  localparam logic [5:0] HMIN = 6'(HR_MIN);
  localparam logic [5:0] HMAX = 6'(HR_MAX);
  localparam logic [5:0] SMAX = 6'd59;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HRS,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]         raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         stable;
  logic [2:0]         stable_q;
  logic [2:0][DW-1:0] db_cnt;
  logic [2:0]         press;

  logic press_mode;
  logic press_up;
  logic press_down;
  logic step;
  logic timeout;
  logic editing;

  logic [TW-1:0] inact;
  logic [5:0]    sh_hrs;
  logic [5:0]    sh_min;
  logic [5:0]    sh_sec;

  assign raw = {btn_down_i, btn_up_i, btn_mode_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_MS ticks of disagreement.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stable   <= '0;
      stable_q <= '0;
      db_cnt   <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_END) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else if (tick_1khz_i) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = stable & ~stable_q;
  assign press_mode = press[0];
  assign press_up   = press[1];
  assign press_down = press[2];
  assign step       = (press_up ^ press_down) & ~press_mode;
  assign timeout    = (inact == TO_END);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (press_mode) state_nx = EDIT_HRS;
      end
      EDIT_HRS: begin
        if (press_mode)   state_nx = EDIT_MIN;
        else if (timeout) state_nx = IDLE;
      end
      EDIT_MIN: begin
        if (press_mode)   state_nx = EDIT_SEC;
        else if (timeout) state_nx = IDLE;
      end
      EDIT_SEC: begin
        if (press_mode)   state_nx = COMMIT;
        else if (timeout) state_nx = IDLE;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    editing = 1'b0;
    field_o = 2'd0;
    unique case (state)
      EDIT_HRS: begin
        editing = 1'b1;
        field_o = 2'd1;
      end
      EDIT_MIN: begin
        editing = 1'b1;
        field_o = 2'd2;
      end
      EDIT_SEC: begin
        editing = 1'b1;
        field_o = 2'd3;
      end
      default: begin
        editing = 1'b0;
        field_o = 2'd0;
      end
    endcase
  end

  assign editing_o  = editing;
  assign set_time_o = (state == COMMIT);

  // Idle also holds the counter at zero, so entry to EDIT_HRS starts fresh.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inact <= '0;
    end else if (!editing || (|press)) begin
      inact <= '0;
    end else if (tick_1khz_i && !timeout) begin
      inact <= inact + 1'b1;
    end
  end

  function automatic logic [5:0] hr_step(input logic [5:0] v,
                                         input logic up);
    if (up) return (v >= HMAX) ? HMIN : v + 6'd1;
    else    return (v <= HMIN) ? HMAX : v - 6'd1;
  endfunction

  function automatic logic [5:0] ms_step(input logic [5:0] v,
                                         input logic up);
    if (up) return (v >= SMAX) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? SMAX : v - 6'd1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sh_hrs <= '0;
      sh_min <= '0;
      sh_sec <= '0;
    end else if (state == IDLE && press_mode) begin
      sh_hrs <= set_hrs_o;
      sh_min <= set_min_o;
      sh_sec <= set_sec_o;
    end else if (step) begin
      unique case (state)
        EDIT_HRS: sh_hrs <= hr_step(sh_hrs, press_up);
        EDIT_MIN: sh_min <= ms_step(sh_min, press_up);
        EDIT_SEC: sh_sec <= ms_step(sh_sec, press_up);
        default: ;
      endcase
    end
  end

  // Load on the edge into COMMIT so values are valid while the strobe is high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      set_hrs_o <= HMIN;
      set_min_o <= '0;
      set_sec_o <= '0;
    end else if (state_nx == COMMIT) begin
      set_hrs_o <= sh_hrs;
      set_min_o <= sh_min;
      set_sec_o <= sh_sec;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEBOUNCE_MS=2, TIMEOUT_MS=50
// and a 1 kHz tick emulated as one pulse every four clocks.
module tb_time_set_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       tick_1khz_i = 1'b0;
  logic       btn_mode_i = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic [5:0] set_hrs_o;
  logic [5:0] set_min_o;
  logic [5:0] set_sec_o;
  logic       set_time_o;
  logic       editing_o;
  logic [1:0] field_o;

  int passes = 0;
  int total = 0;
  int strobes = 0;
  int strobe_base = 0;

  time_set_ctrl #(
    .DEBOUNCE_MS(2),
    .TIMEOUT_MS (50),
    .HR_MIN     (0),
    .HR_MAX     (23)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .tick_1khz_i(tick_1khz_i),
    .btn_mode_i (btn_mode_i),
    .btn_up_i   (btn_up_i),
    .btn_down_i (btn_down_i),
    .set_hrs_o  (set_hrs_o),
    .set_min_o  (set_min_o),
    .set_sec_o  (set_sec_o),
    .set_time_o (set_time_o),
    .editing_o  (editing_o),
    .field_o    (field_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      repeat (3) @(negedge clk_i);
      tick_1khz_i = 1'b1;
      @(negedge clk_i);
      tick_1khz_i = 1'b0;
    end
  end

  always @(posedge clk_i) begin
    if (set_time_o === 1'b1) strobes++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_i); while (tick_1khz_i !== 1'b1);
    end
    @(negedge clk_i);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk_i);
    btn_mode_i = m;
    btn_up_i   = u;
    btn_down_i = d;
    wait_ticks(4);
    btn_mode_i = 1'b0;
    btn_up_i   = 1'b0;
    btn_down_i = 1'b0;
    wait_ticks(4);
  endtask

  initial begin
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_hrs", 32'(set_hrs_o), 0);
    check("rst_min", 32'(set_min_o), 0);
    check("rst_sec", 32'(set_sec_o), 0);
    check("rst_strobe", 32'(set_time_o), 0);
    check("rst_editing", 32'(editing_o), 0);
    check("rst_field", 32'(field_o), 0);
    reset_i = 1'b0;
    wait_ticks(2);

    // one-tick bounce on mode must be filtered
    btn_mode_i = 1'b1;
    repeat (4) @(negedge clk_i);
    btn_mode_i = 1'b0;
    wait_ticks(10);
    check("bounce_editing", 32'(editing_o), 0);
    check("bounce_field", 32'(field_o), 0);

    // up in idle is ignored
    press(0, 1, 0);
    check("idle_up_editing", 32'(editing_o), 0);

    strobe_base = strobes;
    press(1, 0, 0);
    check("enter_field", 32'(field_o), 1);
    check("enter_editing", 32'(editing_o), 1);
    check("idle_up_shadow", 32'(dut.sh_hrs), 0);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    check("hrs_up3", 32'(dut.sh_hrs), 3);
    press(1, 0, 0);
    check("min_field", 32'(field_o), 2);
    press(0, 0, 1);
    check("min_wrap_dn", 32'(dut.sh_min), 59);
    press(1, 0, 0);
    check("sec_field", 32'(field_o), 3);
    check("pre_commit_hrs", 32'(set_hrs_o), 0);
    press(1, 0, 0);
    check("c1_hrs", 32'(set_hrs_o), 3);
    check("c1_min", 32'(set_min_o), 59);
    check("c1_sec", 32'(set_sec_o), 0);
    check("c1_strobes", 32'(strobes - strobe_base), 1);
    check("c1_editing", 32'(editing_o), 0);

    // hour wrap at both ends
    strobe_base = strobes;
    press(1, 0, 0);
    check("load_hrs", 32'(dut.sh_hrs), 3);
    press(0, 0, 1);
    press(0, 0, 1);
    press(0, 0, 1);
    press(0, 0, 1);
    check("hrs_wrap_dn", 32'(dut.sh_hrs), 23);
    press(0, 1, 0);
    check("hrs_wrap_up", 32'(dut.sh_hrs), 0);
    press(0, 0, 1);
    check("hrs_back_23", 32'(dut.sh_hrs), 23);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    check("sec_up", 32'(dut.sh_sec), 1);
    press(0, 1, 1);
    check("sec_updn", 32'(dut.sh_sec), 1);
    check("sec_updn_field", 32'(field_o), 3);
    press(1, 1, 0);
    check("c2_hrs", 32'(set_hrs_o), 23);
    check("c2_min", 32'(set_min_o), 59);
    check("c2_sec", 32'(set_sec_o), 1);
    check("c2_strobes", 32'(strobes - strobe_base), 1);
    check("c2_editing", 32'(editing_o), 0);

    // inactivity timeout in EDIT_MIN
    strobe_base = strobes;
    press(1, 0, 0);
    press(1, 0, 0);
    check("to_field", 32'(field_o), 2);
    press(0, 1, 0);
    check("min_wrap_up", 32'(dut.sh_min), 0);
    wait_ticks(40);
    check("to_pending", 32'(editing_o), 1);
    wait_ticks(10);
    check("to_editing", 32'(editing_o), 0);
    check("to_field_idle", 32'(field_o), 0);
    check("to_hrs", 32'(set_hrs_o), 23);
    check("to_min", 32'(set_min_o), 59);
    check("to_sec", 32'(set_sec_o), 1);
    check("to_strobes", 32'(strobes - strobe_base), 0);

    // asynchronous reset mid EDIT_SEC
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("rs_field", 32'(field_o), 3);
    press(0, 1, 0);
    strobe_base = strobes;
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("rs_hrs", 32'(set_hrs_o), 0);
    check("rs_min", 32'(set_min_o), 0);
    check("rs_sec", 32'(set_sec_o), 0);
    check("rs_editing", 32'(editing_o), 0);
    check("rs_field0", 32'(field_o), 0);
    check("rs_shadow", 32'(dut.sh_sec), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_ticks(20);
    check("rs_strobes", 32'(strobes - strobe_base), 0);
    check("rs_idle", 32'(editing_o), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_MS, default 20: number of 1 kHz ticks a raw button level must hold before it is accepted.
- REQ-002 The block SHALL have parameter TIMEOUT_MS, default 10000: number of ticks without a button press after which an edit is abandoned.
- REQ-003 The block SHALL have parameter HR_MIN, default 0: lowest legal hour value.
- REQ-004 The block SHALL have parameter HR_MAX, default 23: highest legal hour value.
- REQ-005 The block SHALL have input clk_i, 1 bit: system clock, the only clock.
- REQ-006 The block SHALL have input reset_i, 1 bit: asynchronous, active-high reset.
- REQ-007 The block SHALL have input tick_1khz_i, 1 bit: one-clk_i-cycle enable pulse at 1 kHz.
- REQ-008 The block SHALL have inputs btn_mode_i, btn_up_i and btn_down_i, 1 bit each: raw, asynchronous, active-high buttons.
- REQ-009 The block SHALL have output set_hrs_o, 6 bits: committed hour.
- REQ-010 The block SHALL have outputs set_min_o and set_sec_o, 6 bits each: committed minute and second.
- REQ-011 The block SHALL have output set_time_o, 1 bit: one-cycle load strobe for the clock, timer and stopwatch counters.
- REQ-012 The block SHALL have output editing_o, 1 bit: high while in any EDIT state.
- REQ-013 The block SHALL have output field_o, 2 bits: field under edit (0 none, 1 hrs, 2 min, 3 sec).

Function
- REQ-014 Each button SHALL pass through a 2-flop synchroniser before any other logic.
- REQ-015 Each button SHALL have a debounce counter that advances on tick_1khz_i while the synchronised level differs from the stable level.
- REQ-016 The debounce counter SHALL clear whenever the synchronised level equals the stable level.
- REQ-017 The stable level SHALL take the synchronised level when its counter reaches DEBOUNCE_MS, and the counter SHALL clear at the same time.
- REQ-018 A 0->1 transition of a stable level SHALL produce exactly one press event, one clk_i cycle long; holding a button SHALL NOT auto-repeat.
- REQ-019 The FSM SHALL have states IDLE, EDIT_HRS, EDIT_MIN, EDIT_SEC and COMMIT.
- REQ-020 A mode press in IDLE SHALL go to EDIT_HRS and load the hrs, min and sec shadow registers from set_*_o.
- REQ-021 A mode press SHALL advance EDIT_HRS->EDIT_MIN->EDIT_SEC->COMMIT.
- REQ-022 COMMIT SHALL last exactly one cycle, copy the shadow registers into set_*_o on that edge, assert set_time_o for that cycle only, then return to IDLE.
- REQ-023 In an EDIT state, an up press SHALL increment the active shadow field by 1 and a down press SHALL decrement it by 1.
- REQ-024 The hour field SHALL wrap HR_MAX->HR_MIN on increment and HR_MIN->HR_MAX on decrement.
- REQ-025 The minute and second fields SHALL wrap 59->0 on increment and 0->59 on decrement.
- REQ-026 Up and down presses in the same cycle SHALL leave the shadow field unchanged.
- REQ-027 A mode press SHALL take priority over an up or down press in the same cycle; the up or down press SHALL be discarded.
- REQ-028 Up and down presses in IDLE SHALL be ignored.
- REQ-029 An inactivity counter SHALL clear on every press and on entry to EDIT_HRS, and SHALL advance on each tick in EDIT states.
- REQ-030 When the inactivity counter reaches TIMEOUT_MS, the FSM SHALL return to IDLE with no commit; set_*_o SHALL be unchanged and set_time_o SHALL stay low.
- REQ-031 set_*_o SHALL change only in COMMIT and SHALL always hold values within range.
- REQ-032 editing_o and field_o SHALL be decoded from the registered FSM state.

Reset
- REQ-033 reset_i SHALL asynchronously force the FSM to IDLE.
- REQ-034 reset_i SHALL asynchronously force set_hrs_o=HR_MIN, set_min_o=0, set_sec_o=0, set_time_o=0, editing_o=0 and field_o=0.
- REQ-035 reset_i SHALL asynchronously clear all debounce, inactivity and shadow registers.
- REQ-036 reset_i SHALL asynchronously clear all synchroniser flops and stable levels to 0.
- REQ-037 A reset during an edit SHALL discard the edit with no set_time_o pulse.

Verification (bench uses DEBOUNCE_MS=2, TIMEOUT_MS=50)
- REQ-038 Button pulse of 1 tick (bounce) -> no press event and no state change.
- REQ-039 mode, up x3, mode, down x1, mode, mode (from reset) -> set_hrs_o=3, set_min_o=59, set_sec_o=0, exactly one set_time_o pulse.
- REQ-040 In EDIT_HRS at 23, press up -> shadow 0; press down -> shadow 23 (HR_MIN=0, HR_MAX=23).
- REQ-041 Up and down released-to-pressed together in EDIT_SEC -> field unchanged; mode and up together -> advances to COMMIT with sec unchanged.
- REQ-042 Enter EDIT_MIN, wait 50 ticks with no press -> IDLE, editing_o=0, outputs unchanged, no set_time_o.
- REQ-043 Assert reset_i mid-EDIT_SEC between clock edges -> outputs at reset values immediately, no strobe after release.
